// File: rtl/if_id_queue_pkg.sv
// Shared constants and bundle types for the IF/ID instruction queue.
// Optional same-cycle bypass is enabled by defining IFQ_BYPASS_EN.
package if_id_queue_pkg;

  localparam logic [31:0] ZeroWord = 32'h0;
  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;

  localparam logic [1:0]  STL_NONE = 2'b00;

  localparam logic [31:0] IFQ_BUBBLE_INST = ZeroWord;
  localparam logic [31:0] IFQ_BUBBLE_PC   = ZeroWord;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } if_id_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular {inst,pc} store with wrap-around pointers and occupancy count.
// Push while full is ignored; clear empties the queue and drops a push.
module ifq_fifo
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   dclk,
  input  logic   rst,
  input  logic   i_push,
  input  logic   i_pop,
  input  logic   i_clr,
  input  if_id_t i_data,
  output if_id_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;
  if_id_t           r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wr <= r_wr + 1'b1;
      if (w_pop)
        r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone defines valid entries.
  always_ff @(posedge dclk) begin
    if (w_push && !i_clr)
      r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/if_id_queue.sv
// IF->ID instruction queue with registered ID outputs and bubble counter.
// Define IFQ_BYPASS_EN to forward into an empty queue with 1-edge latency.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic [1:0]       stl_i,
  input  logic             valid_IF_i,
  input  logic [31:0]      inst_IF_i,
  input  logic [31:0]      pc_IF_i,
  input  logic             flush_EX_i,
  output logic             full_IF_o,
  output logic             valid_ID_o,
  output logic [31:0]      inst_ID_o,
  output logic [31:0]      pc_ID_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic             r_valid;
  logic [31:0]      r_inst;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_bcnt;

  logic   w_stall;
  logic   w_full;
  logic   w_empty;
  logic   w_byp;
  logic   w_push;
  logic   w_pop;
  if_id_t w_in;
  if_id_t w_head;

  assign w_stall = (stl_i != STL_NONE);
  assign w_in    = '{inst: inst_IF_i, pc: pc_IF_i};

`ifdef IFQ_BYPASS_EN
  assign w_byp = w_empty && !w_stall && valid_IF_i && !flush_EX_i;
`else
  assign w_byp = Disable;
`endif

  assign w_push = valid_IF_i && !w_byp && !flush_EX_i;
  assign w_pop  = !w_stall && !flush_EX_i;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .dclk    (dclk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clr   (flush_EX_i),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      r_valid <= Disable;
      r_inst  <= IFQ_BUBBLE_INST;
      r_pc    <= IFQ_BUBBLE_PC;
      r_bcnt  <= '0;
    end else if (flush_EX_i) begin
      r_valid <= Disable;
      r_inst  <= IFQ_BUBBLE_INST;
      r_pc    <= IFQ_BUBBLE_PC;
    end else if (!w_stall) begin
      if (w_byp) begin
        r_valid <= Enable;
        r_inst  <= inst_IF_i;
        r_pc    <= pc_IF_i;
      end else if (!w_empty) begin
        r_valid <= Enable;
        r_inst  <= w_head.inst;
        r_pc    <= w_head.pc;
      end else begin
        r_valid <= Disable;
        r_inst  <= IFQ_BUBBLE_INST;
        r_pc    <= IFQ_BUBBLE_PC;
        if (r_bcnt != '1)
          r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  assign full_IF_o    = w_full;
  assign valid_ID_o   = r_valid;
  assign inst_ID_o    = r_inst;
  assign pc_ID_o      = r_pc;
  assign bubble_cnt_o = r_bcnt;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios plus random traffic
// against a queue-based reference model of the IF/ID behaviour.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             dclk = 1'b0;
  logic             rst  = 1'b1;
  logic [1:0]       stl_i = 2'b00;
  logic             valid_IF_i = 1'b0;
  logic [31:0]      inst_IF_i = '0;
  logic [31:0]      pc_IF_i = '0;
  logic             flush_EX_i = 1'b0;
  logic             full_IF_o;
  logic             valid_ID_o;
  logic [31:0]      inst_ID_o;
  logic [31:0]      pc_ID_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  int          m_bcnt;

  if_id_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .dclk         (dclk),
    .rst          (rst),
    .stl_i        (stl_i),
    .valid_IF_i   (valid_IF_i),
    .inst_IF_i    (inst_IF_i),
    .pc_IF_i      (pc_IF_i),
    .flush_EX_i   (flush_EX_i),
    .full_IF_o    (full_IF_o),
    .valid_ID_o   (valid_ID_o),
    .inst_ID_o    (inst_ID_o),
    .pc_ID_o      (pc_ID_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_valid = 1'b0;
    m_inst  = '0;
    m_pc    = '0;
    m_bcnt  = 0;
  endtask

  task automatic m_bubble(input bit count_it);
    m_valid = 1'b0;
    m_inst  = '0;
    m_pc    = '0;
    if (count_it && m_bcnt < (1 << CNT_W) - 1)
      m_bcnt++;
  endtask

  task automatic m_step();
    bit          can_push;
    logic [63:0] e;
    can_push = valid_IF_i && (mq.size() < DEPTH);
    if (flush_EX_i) begin
      mq.delete();
      m_bubble(1'b0);
    end else if (stl_i != 2'b00) begin
      if (can_push) mq.push_back({inst_IF_i, pc_IF_i});
    end else if (BYP && mq.size() == 0 && valid_IF_i) begin
      m_valid = 1'b1;
      m_inst  = inst_IF_i;
      m_pc    = pc_IF_i;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_valid = 1'b1;
        m_inst  = e[63:32];
        m_pc    = e[31:0];
      end else begin
        m_bubble(1'b1);
      end
      if (can_push) mq.push_back({inst_IF_i, pc_IF_i});
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, {31'b0, valid_ID_o}, {31'b0, m_valid});
    chk({tag, ".inst"}, inst_ID_o, m_inst);
    chk({tag, ".pc"}, pc_ID_o, m_pc);
    chk({tag, ".bcnt"}, 32'(bubble_cnt_o), 32'(m_bcnt));
    chk({tag, ".full"}, {31'b0, full_IF_o},
        {31'b0, mq.size() == DEPTH});
  endtask

  task automatic cyc(input string tag, input logic [1:0] stl,
                     input logic v, input logic [31:0] inst,
                     input logic [31:0] pc, input logic fl);
    stl_i      = stl;
    valid_IF_i = v;
    inst_IF_i  = inst;
    pc_IF_i    = pc;
    flush_EX_i = fl;
    @(posedge dclk);
    m_step();
    #1;
    chk_all(tag);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk_all("rst_async");
    #1 rst = 1'b0;
  endtask

  initial begin
    m_reset();
    #1;
    chk_all("reset");
    #11 rst = 1'b0;

    cyc("lat_push", 2'd0, 1'b1, 32'h00A00093, 32'h0, 1'b0);
    if (BYP)
      chk("lat1", inst_ID_o, 32'h00A00093);
    cyc("lat_idle", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    if (!BYP)
      chk("lat2", inst_ID_o, 32'h00A00093);

    mid_reset();
    for (int i = 0; i < 5; i++)
      cyc("stall_fill", 2'd1, 1'b1, 32'h1000 + i, 32'h4 * i, 1'b0);
    chk("full_flag", {31'b0, full_IF_o}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      cyc("drain", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("drain_order", inst_ID_o, 32'h1000 + i);
    end
    cyc("drain_bub", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("bcnt_one", 32'(bubble_cnt_o), 32'h1);

    for (int i = 0; i < 3; i++)
      cyc("pre_flush", 2'd2, 1'b1, 32'h2000 + i, 32'h100 + i, 1'b0);
    cyc("flush", 2'd2, 1'b1, 32'hDEAD, 32'hBEEF, 1'b1);
    chk("flush_bcnt", 32'(bubble_cnt_o), 32'h1);
    cyc("post_flush", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 2; i++)
      cyc("wrap_pre", 2'd3, 1'b1, 32'h3000 + i, 32'h200 + i, 1'b0);
    for (int i = 2; i < 12; i++)
      cyc("wrap", 2'd0, 1'b1, 32'h3000 + i, 32'h200 + i, 1'b0);

    mid_reset();
    cyc("after_rst", 2'd0, 1'b1, 32'h4444, 32'h40, 1'b0);
    cyc("after_rst2", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("first_out", inst_ID_o, 32'h4444);

    for (int i = 0; i < 20; i++)
      cyc("sat", 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("sat_F", 32'(bubble_cnt_o), 32'hF);

    mid_reset();
    for (int i = 0; i < 400; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cyc("rand", s, 1'($urandom_range(0, 1)), $urandom, $urandom,
          ($urandom_range(0, 24) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
